// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader:
// FSM state encoding, byte-lane geometry and the default image size limit.
package boot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } boot_state_e;

    localparam int         LANE_W            = 8;
    localparam int         LANES             = 4;
    localparam int         WORD_W            = LANE_W * LANES;
    localparam logic [1:0] LAST_LANE         = 2'(LANES - 1);
    localparam int         MAX_WORDS_DEFAULT = 256;

endpackage

// File: rtl/word_packer.sv
// Assembles a little-endian 32-bit word from a stream of accepted bytes;
// word_last flags the cycle in which the fourth byte of a word is taken.
module word_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [LANE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_last
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    assign word      = word_q;
    assign word_last = accept && (cnt_q == LAST_LANE);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (accept) begin
            cnt_d  = cnt_q + 2'd1;
            // Shifting in from the top leaves the first byte in [7:0] after four bytes.
            word_d = {byte_in, word_q[WORD_W-1:LANE_W]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: receives an image byte stream, writes it word by word into
// instruction memory, then releases the core. Optional BOOT_CHECKSUM_EN adds a trailing sum check.
module imem_boot_ctrl
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] len_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] imem_din,
    output logic [31:0] imem_addr,
    output logic        imem_web,
    output logic        core_rstn,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    boot_state_e       state_q, state_d;
    logic [15:0]       index_q, index_d;
    logic [15:0]       len_q, len_d;
    logic              err_q, err_d;
    logic              byte_accept, word_last, pk_clear;
    logic              len_ok, last_index;
    logic [WORD_W-1:0] pk_word;

`ifdef BOOT_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;
    logic              chk_q, chk_d;
    logic [WORD_W-1:0] chk_word;

    // The trailing word is compared as it completes, before it lands in the packer.
    assign chk_word = {byte_data, pk_word[WORD_W-1:LANE_W]};
`endif

    word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .accept    (byte_accept),
        .byte_in   (byte_data),
        .word      (pk_word),
        .word_last (word_last)
    );

    assign len_ok      = (len_words != 16'd0) && (32'(len_words) <= MAX_LEN);
    assign last_index  = (index_q + 16'd1) == len_q;
    assign byte_accept = byte_valid && byte_ready;

    // Outputs decode the state register directly, so an async reset releases the strobe at once.
    assign byte_ready = (state_q == RECV);
    assign imem_web   = (state_q != WRITE);
    assign core_rstn  = (state_q == RUN);
    assign done       = (state_q == RUN);
    assign busy       = (state_q == RECV) || (state_q == WRITE);
    assign err        = err_q;
    assign imem_din   = pk_word;
    assign imem_addr  = BASE_ADDR + {14'd0, index_q, 2'b00};

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        len_d    = len_q;
        err_d    = err_q;
        pk_clear = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_d    = sum_q;
        chk_d    = chk_q;
`endif
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    if (len_ok) begin
                        state_d  = RECV;
                        index_d  = '0;
                        len_d    = len_words;
                        err_d    = 1'b0;
                        pk_clear = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        sum_d    = '0;
                        chk_d    = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            RECV: begin
                if (abort) begin
                    state_d  = IDLE;
                    err_d    = 1'b1;
                    pk_clear = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    chk_d    = 1'b0;
`endif
                end else if (word_last) begin
`ifdef BOOT_CHECKSUM_EN
                    if (chk_q) begin
                        chk_d = 1'b0;
                        if (chk_word == sum_q) begin
                            state_d = RUN;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = WRITE;
                    end
`else
                    state_d = WRITE;
`endif
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d  = IDLE;
                    err_d    = 1'b1;
                    pk_clear = 1'b1;
                end else begin
`ifdef BOOT_CHECKSUM_EN
                    sum_d = sum_q + pk_word;
`endif
                    if (last_index) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = RECV;
                        chk_d   = 1'b1;
`else
                        state_d = RUN;
`endif
                    end else begin
                        index_d = index_q + 16'd1;
                        state_d = RECV;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            len_q   <= len_d;
            err_q   <= err_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= sum_d;
            chk_q   <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: random images are streamed in and
// the observed memory writes and status flags are compared with a simple image model.
module tb_imem_boot_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0000;

`ifdef BOOT_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef logic [31:0] wq_t[$];
    typedef logic [7:0]  bq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] len_words = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, imem_web, core_rstn, busy, done, err;
    logic [31:0] imem_din, imem_addr;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t wr_q[$];

    imem_boot_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .len_words  (len_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_din   (imem_din),
        .imem_addr  (imem_addr),
        .imem_web   (imem_web),
        .core_rstn  (core_rstn),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Every cycle the strobe is low counts as one memory write.
    always @(negedge clk) begin
        if (rst === 1'b0 && imem_web === 1'b0) wr_q.push_back('{imem_addr, imem_din});
    end

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    // Little-endian byte image; optionally followed by the wrapping word sum plus an offset.
    function automatic bq_t image_bytes(input wq_t w, input bit add_sum, input logic [31:0] sum_adj);
        bq_t         b;
        logic [31:0] s = 32'h0;
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) b.push_back(w[i][8*k +: 8]);
            s = s + w[i];
        end
        if (add_sum) begin
            s = s + sum_adj;
            for (int k = 0; k < 4; k++) b.push_back(s[8*k +: 8]);
        end
        return b;
    endfunction

    task automatic do_start(input logic [15:0] len);
        @(negedge clk);
        start     = 1'b1;
        len_words = len;
        @(negedge clk);
        start     = 1'b0;
        len_words = 16'($urandom);
    endtask

    // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid.
    task automatic send_bytes(input bq_t b, input int mode, output bit timed_out);
        int i = 0;
        int cyc = 0;
        bit ph = 1'b0;
        timed_out = 1'b0;
        while (i < b.size()) begin
            @(negedge clk);
            if (cyc > 4000) begin
                timed_out = 1'b1;
                break;
            end
            cyc++;
            ph = ~ph;
            case (mode)
                1:       byte_valid = ph;
                2:       byte_valid = 1'($urandom_range(0, 1));
                default: byte_valid = 1'b1;
            endcase
            byte_data = byte_valid ? b[i] : 8'($urandom);
            if (byte_valid && byte_ready) i++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done || err) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load(input wq_t w, input int mode, output bit ok);
        bit to;
        do_start(16'(w.size()));
        send_bytes(image_bytes(w, CHK, 32'h0), mode, to);
        wait_end(ok);
        ok = ok && !to;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({core_rstn, imem_web, byte_ready, busy, done, err} !== 6'b010000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 010000", {core_rstn, imem_web, byte_ready, busy, done, err});
        end
        n_tests++;
        if (imem_din !== 32'h0 || imem_addr !== BASE) begin
            n_fail++;
            $display("FAIL reset_bus: got din=%h addr=%h want din=0 addr=%h", imem_din, imem_addr, BASE);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({core_rstn, busy, done, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b want 0000", {core_rstn, busy, done, err});
        end
    endtask

    task automatic test_basic();
        wq_t w = '{32'h0000_0013, 32'h0010_0093};
        bit  ok, to;
        wr_q.delete();
        do_start(16'd2);
        n_tests++;
        if ({busy, byte_ready, core_rstn, done, err} !== 5'b11000) begin
            n_fail++;
            $display("FAIL basic_recv_flags: got %b want 11000", {busy, byte_ready, core_rstn, done, err});
        end
        send_bytes(image_bytes(w, CHK, 32'h0), 0, to);
        wait_end(ok);
        n_tests++;
        if (!ok || to) begin
            n_fail++;
            $display("FAIL basic_timeout: got done=%b err=%b want done=1", done, err);
        end
        n_tests++;
        if (wr_q.size() != 2) begin
            n_fail++;
            $display("FAIL basic_wr_count: got %0d want 2", wr_q.size());
        end
        for (int i = 0; i < 2 && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i].addr !== BASE + 32'(4*i) || wr_q[i].data !== w[i]) begin
                n_fail++;
                $display("FAIL basic_wr%0d: got %h@%h want %h@%h", i, wr_q[i].data, wr_q[i].addr, w[i], BASE + 32'(4*i));
            end
        end
        n_tests++;
        if ({core_rstn, done, busy, err, imem_web} !== 5'b11001) begin
            n_fail++;
            $display("FAIL basic_run_flags: got %b want 11001", {core_rstn, done, busy, err, imem_web});
        end
    endtask

    task automatic test_throttle();
        wq_t w = rand_words($urandom_range(3, 6));
        bit  ok;
        wr_q.delete();
        load(w, 1, ok);
        n_tests++;
        if (!ok || done !== 1'b1) begin
            n_fail++;
            $display("FAIL throttle_done: got done=%b err=%b want done=1", done, err);
        end
        n_tests++;
        if (wr_q.size() != w.size()) begin
            n_fail++;
            $display("FAIL throttle_wr_count: got %0d want %0d", wr_q.size(), w.size());
        end
        for (int i = 0; i < w.size() && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i].addr !== BASE + 32'(4*i) || wr_q[i].data !== w[i]) begin
                n_fail++;
                $display("FAIL throttle_wr%0d: got %h@%h want %h@%h", i, wr_q[i].data, wr_q[i].addr, w[i], BASE + 32'(4*i));
            end
        end
    endtask

    task automatic test_bad_len();
        logic [15:0] lens[3] = '{16'd0, 16'd257, 16'd65535};
        wr_q.delete();
        foreach (lens[j]) begin
            do_start(lens[j]);
            byte_valid = 1'b1;
            repeat (5) @(negedge clk);
            byte_valid = 1'b0;
            n_tests++;
            if ({err, core_rstn, busy, done, byte_ready} !== 5'b10000 || wr_q.size() != 0) begin
                n_fail++;
                $display("FAIL bad_len_%0d: got flags=%b writes=%0d want flags=10000 writes=0",
                         lens[j], {err, core_rstn, busy, done, byte_ready}, wr_q.size());
            end
        end
        do_start(16'd256);
        n_tests++;
        if ({busy, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL max_len_accept: got busy=%b err=%b want busy=1 err=0", busy, err);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_abort();
        wq_t w  = rand_words(2);
        wq_t w2 = rand_words(2);
        bq_t b  = image_bytes(w, 1'b0, 32'h0);
        bq_t b6;
        bit  ok, to;
        for (int i = 0; i < 6; i++) b6.push_back(b[i]);
        wr_q.delete();
        do_start(16'd2);
        send_bytes(b6, 2, to);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if ({err, busy, core_rstn, done, byte_ready} !== 5'b10000 || to) begin
            n_fail++;
            $display("FAIL abort_flags: got %b want 10000", {err, busy, core_rstn, done, byte_ready});
        end
        n_tests++;
        if (wr_q.size() != 1 || wr_q[0].data !== w[0] || wr_q[0].addr !== BASE) begin
            n_fail++;
            $display("FAIL abort_writes: got count=%0d want 1 write of %h@%h", wr_q.size(), w[0], BASE);
        end
        wr_q.delete();
        load(w2, 0, ok);
        n_tests++;
        if (!ok || wr_q.size() != 2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reload: got ok=%b count=%0d err=%b want ok=1 count=2 err=0", ok, wr_q.size(), err);
        end
        for (int i = 0; i < 2 && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i].addr !== BASE + 32'(4*i) || wr_q[i].data !== w2[i]) begin
                n_fail++;
                $display("FAIL abort_reload_wr%0d: got %h@%h want %h@%h", i, wr_q[i].data, wr_q[i].addr, w2[i], BASE + 32'(4*i));
            end
        end
        // abort and start together in RECV: the abort wins.
        do_start(16'd1);
        @(negedge clk);
        abort     = 1'b1;
        start     = 1'b1;
        len_words = 16'd1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        n_tests++;
        if ({err, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_start_same: got err=%b busy=%b want err=1 busy=0", err, busy);
        end
    endtask

    task automatic test_run_restart();
        wq_t w1 = rand_words(1);
        wq_t w  = rand_words(3);
        bq_t b  = image_bytes(w, CHK, 32'h0);
        bq_t b_head, b_tail;
        bit  ok, to1, to2;
        load(w1, 0, ok);
        @(negedge clk);
        start     = 1'b1;
        len_words = 16'd3;
        @(posedge clk);
        #1;
        n_tests++;
        if ({core_rstn, done, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL restart_core_rstn: got rstn=%b done=%b busy=%b want 0 0 1", core_rstn, done, busy);
        end
        @(negedge clk);
        start = 1'b0;
        wr_q.delete();
        for (int i = 0; i < b.size(); i++) begin
            if (i < 5) b_head.push_back(b[i]);
            else       b_tail.push_back(b[i]);
        end
        send_bytes(b_head, 0, to1);
        // A start mid-load must be ignored.
        start     = 1'b1;
        len_words = 16'd1;
        @(negedge clk);
        start = 1'b0;
        send_bytes(b_tail, 1, to2);
        wait_end(ok);
        n_tests++;
        if (!ok || to1 || to2 || done !== 1'b1 || wr_q.size() != 3) begin
            n_fail++;
            $display("FAIL restart_reload: got done=%b count=%0d want done=1 count=3", done, wr_q.size());
        end
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i].addr !== BASE + 32'(4*i) || wr_q[i].data !== w[i]) begin
                n_fail++;
                $display("FAIL restart_wr%0d: got %h@%h want %h@%h", i, wr_q[i].data, wr_q[i].addr, w[i], BASE + 32'(4*i));
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            wq_t w = rand_words($urandom_range(1, 8));
            bit  ok;
            wr_q.delete();
            load(w, $urandom_range(0, 2), ok);
            n_tests++;
            if (!ok || done !== 1'b1 || wr_q.size() != w.size()) begin
                n_fail++;
                $display("FAIL random%0d_done: got done=%b count=%0d want done=1 count=%0d", t, done, wr_q.size(), w.size());
            end
            for (int i = 0; i < w.size() && i < wr_q.size(); i++) begin
                n_tests++;
                if (wr_q[i].addr !== BASE + 32'(4*i) || wr_q[i].data !== w[i]) begin
                    n_fail++;
                    $display("FAIL random%0d_wr%0d: got %h@%h want %h@%h", t, i, wr_q[i].data, wr_q[i].addr, w[i], BASE + 32'(4*i));
                end
            end
        end
    endtask

    task automatic test_midwrite_reset();
        bq_t b = '{8'h11, 8'h22, 8'h33};
        bit  to;
        do_start(16'd1);
        send_bytes(b, 0, to);
        byte_valid = 1'b1;
        byte_data  = 8'h44;
        @(posedge clk);
        #2;
        byte_valid = 1'b0;
        n_tests++;
        if (imem_web !== 1'b0 || to) begin
            n_fail++;
            $display("FAIL midwrite_strobe: got web=%b want 0", imem_web);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({imem_web, core_rstn, busy, byte_ready} !== 4'b1000 || imem_din !== 32'h0 || imem_addr !== BASE) begin
            n_fail++;
            $display("FAIL midwrite_reset: got web/rstn/busy/rdy=%b din=%h addr=%h want 1000 0 %h",
                     {imem_web, core_rstn, busy, byte_ready}, imem_din, imem_addr, BASE);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        wq_t w = '{32'h0000_0013, 32'h0010_0093};
        bit  ok, to;
        wr_q.delete();
        do_start(16'd2);
        send_bytes(image_bytes(w, 1'b1, 32'h0), 0, to);
        wait_end(ok);
        n_tests++;
        if (!ok || to || {done, core_rstn, err} !== 3'b110 || wr_q.size() != 2) begin
            n_fail++;
            $display("FAIL checksum_good: got done=%b rstn=%b err=%b writes=%0d want 1 1 0 2", done, core_rstn, err, wr_q.size());
        end
        wr_q.delete();
        do_start(16'd2);
        send_bytes(image_bytes(w, 1'b1, 32'h1), 0, to);
        wait_end(ok);
        n_tests++;
        if (!ok || to || {done, core_rstn, err, busy} !== 4'b0010 || wr_q.size() != 2) begin
            n_fail++;
            $display("FAIL checksum_bad: got done=%b rstn=%b err=%b busy=%b writes=%0d want 0 0 1 0 2",
                     done, core_rstn, err, busy, wr_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_throttle();
        test_bad_len();
        test_abort();
        test_run_restart();
        test_random();
        test_midwrite_reset();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word.
REQ-002 SHALL have parameter MAX_WORDS, default 256, the largest accepted image length in words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins an image load.
REQ-006 SHALL have port abort, input, 1 bit: single-cycle pulse that cancels a load in progress.
REQ-007 SHALL have port len_words, input, 16 bits: image length in words, sampled on an accepted start.
REQ-008 SHALL have port byte_valid, input, 1 bit: byte_data is valid.
REQ-009 SHALL have port byte_data, input, 8 bits: incoming image byte.
REQ-010 SHALL have port byte_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-011 SHALL have port imem_din, output, 32 bits: instruction memory write data.
REQ-012 SHALL have port imem_addr, output, 32 bits: instruction memory byte address.
REQ-013 SHALL have port imem_web, output, 1 bit: active-low instruction memory write strobe.
REQ-014 SHALL have port core_rstn, output, 1 bit: active-low reset to the pipeline core.
REQ-015 SHALL have ports busy, done and err, outputs, 1 bit each: status flags.

Function
REQ-016 SHALL implement the states IDLE, RECV, WRITE and RUN.
REQ-017 SHALL, in IDLE or RUN, on start with 1 <= len_words <= MAX_WORDS, move to RECV and clear done, err and the word index.
REQ-018 SHALL, on start with len_words = 0 or len_words > MAX_WORDS, set err and enter IDLE with core_rstn = 0.
REQ-019 SHALL drive byte_ready = 1 only in RECV, and accept a byte only when byte_valid and byte_ready are both 1.
REQ-020 SHALL pack accepted bytes little-endian: the first byte goes to bits [7:0], the fourth to bits [31:24].
REQ-021 SHALL, on the cycle after the fourth byte is accepted, be in WRITE with imem_web = 0 for exactly one cycle.
REQ-022 SHALL, during WRITE, drive imem_addr = BASE_ADDR + 4*index (modulo 2^32) and imem_din = the packed word.
REQ-023 SHALL, after WRITE, increment index and return to RECV, or enter RUN if index + 1 equals len_words.
REQ-024 SHALL drive core_rstn = 1 only in RUN, and 0 from the cycle after start is accepted.
REQ-025 SHALL set done = 1 in RUN, and busy = 1 in RECV and WRITE.
REQ-026 SHALL, on abort in RECV or WRITE, enter IDLE with core_rstn = 0, discard any partial word, and set err.
REQ-027 SHALL give abort priority when abort and start occur in the same cycle.
REQ-028 SHALL ignore abort in IDLE and RUN.
REQ-029 SHALL ignore start in RECV and WRITE.
REQ-030 SHALL hold imem_web = 1 in every state other than WRITE.

Reset
REQ-031 SHALL, while rst is high, force: state IDLE, core_rstn 0, imem_web 1, imem_din 0, imem_addr BASE_ADDR, byte_ready 0, busy 0, done 0, err 0, index 0, byte count 0.
REQ-032 SHALL, when rst asserts mid-write, release imem_web to 1 immediately, without waiting for a clock edge.

Configuration
REQ-033 SHALL, with BOOT_CHECKSUM_EN defined, keep a 32-bit wrapping sum of all written words and, after the last word, receive one extra 4-byte word that is not written to memory.
REQ-034 SHALL, with BOOT_CHECKSUM_EN defined, enter RUN if that extra word equals the sum, and otherwise set err and enter IDLE with core_rstn = 0.
REQ-035 SHALL, without BOOT_CHECKSUM_EN, contain no checksum logic and enter RUN directly after the last WRITE.

Structure
REQ-036 SHALL place the state enum, the byte-lane constants and the MAX_WORDS default in the shared package boot_pkg.
REQ-037 SHALL implement the byte-to-word packing (byte counter and shift register) as the sub-module word_packer.

Verification
REQ-038 SHALL cover: start, len_words = 2, bytes 13,00,00,00,93,00,10,00 -> writes 0x00000013 @0x0 then 0x00100093 @0x4, then core_rstn = 1 and done = 1.
REQ-039 SHALL cover: byte_valid toggling every other cycle -> no byte lost or duplicated, and exactly one imem_web low per word.
REQ-040 SHALL cover: len_words = 0, and len_words = 257 with default MAX_WORDS -> err = 1, no write, core_rstn = 0.
REQ-041 SHALL cover: abort after 6 of 8 bytes -> exactly one write, IDLE, err = 1; a new start then reloads from BASE_ADDR.
REQ-042 SHALL cover: start in RUN -> core_rstn = 0 on the next cycle, followed by a full reload.
REQ-043 SHALL cover, with BOOT_CHECKSUM_EN: correct sum 0x001000A6 -> RUN; sum 0x001000A7 -> err = 1 and core_rstn = 0.
